mul_div_seq: RTL



---
 rtl/mul_div_seq_if.sv | 25 ++
 rtl/mul_div_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mul_div_seq_if.sv
// Handshake and operand/result bundle between the controller and the
// iterative multiply/divide unit.
interface mul_div_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/mul_div_seq.sv
// 16-bit iterative unsigned multiply (shift-add) / divide (restoring),
// one bit per cycle, with start/busy/done handshake.
module mul_div_seq #(
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         rst,
  mul_div_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_r;
  logic               op_r;
  logic [WIDTH-1:0]   a_hold_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH:0]     rem_r;
  logic [4:0]         cnt_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   hi_r;
  logic               dbz_r;

  logic [WIDTH+1:0]   shift_rem_s;
  logic [WIDTH+1:0]   diff_s;
  logic               borrow_s;
  logic [2*WIDTH-1:0] acc_nxt_s;
  logic [WIDTH:0]     rem_nxt_s;
  logic [WIDTH-1:0]   mplier_nxt_s;
  logic               last_s;
  logic               dbz_s;

  // One iteration of the selected algorithm. The dividend MSB is taken from
  // the multiplicand shifter, which shifts left identically for both ops.
  always_comb begin
    shift_rem_s  = {rem_r, mcand_r[WIDTH-1]};
    diff_s       = shift_rem_s - {2'b00, mplier_r};
    borrow_s     = diff_s[WIDTH+1];
    acc_nxt_s    = acc_r;
    rem_nxt_s    = rem_r;
    mplier_nxt_s = mplier_r;
    if (op_r) begin
      acc_nxt_s = {acc_r[2*WIDTH-2:0], ~borrow_s};
      rem_nxt_s = borrow_s ? shift_rem_s[WIDTH:0] : diff_s[WIDTH:0];
    end else begin
      acc_nxt_s    = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
      mplier_nxt_s = {1'b0, mplier_r[WIDTH-1:1]};
    end
    last_s = (cnt_r == 5'd15);
    dbz_s  = op_r && (mplier_r == {WIDTH{1'b0}});
  end

  // Control FSM, datapath registers and held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      op_r     <= 1'b0;
      a_hold_r <= {WIDTH{1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      rem_r    <= {(WIDTH+1){1'b0}};
      cnt_r    <= 5'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      lo_r     <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      dbz_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            op_r     <= bus.op;
            a_hold_r <= bus.a;
            mcand_r  <= {{WIDTH{1'b0}}, bus.a};
            mplier_r <= bus.b;
            acc_r    <= {(2*WIDTH){1'b0}};
            rem_r    <= {(WIDTH+1){1'b0}};
            cnt_r    <= 5'd0;
            busy_r   <= 1'b1;
            state_r  <= ST_BUSY;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          acc_r    <= acc_nxt_s;
          rem_r    <= rem_nxt_s;
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= mplier_nxt_s;
          cnt_r    <= cnt_r + 5'd1;
          if (last_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
            dbz_r   <= dbz_s;
            if (dbz_s) begin
              lo_r <= {WIDTH{1'b1}};
              hi_r <= a_hold_r;
            end else if (op_r) begin
              lo_r <= acc_nxt_s[WIDTH-1:0];
              hi_r <= rem_nxt_s[WIDTH-1:0];
            end else begin
              lo_r <= acc_nxt_s[WIDTH-1:0];
              hi_r <= acc_nxt_s[2*WIDTH-1:WIDTH];
            end
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.result_lo   = lo_r;
  assign bus.result_hi   = hi_r;
  assign bus.div_by_zero = dbz_r;

endmodule
